// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam int unsigned P_CPU      = 0;
    localparam int unsigned P_DMA      = 1;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory-side bus of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_adr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                memwr;
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   wrdata;
    logic [DATA_W-1:0]   memdata;

    modport slave (
        input  req_valid, req_we, req_adr, req_wdata, memdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, memwr, adr, wrdata
    );

    modport master (
        output req_valid, req_we, req_adr, req_wdata, memdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, memwr, adr, wrdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port other than i_last_gnt wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = i_valid;
        if (&i_valid) begin
            o_gnt = i_last_gnt ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between CPU (port 0) and DMA (port 1).
// Optional MEM_WP_EN: blocks port-1 writes below WP_LIMIT and flags rsp_err.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter int unsigned       DATA_W      = DEF_DATA_W,
    parameter int unsigned       WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] WP_LIMIT    = ADDR_W'(8'h10)
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    logic [1:0]        w_gnt;
    logic              w_port;
    logic              w_acc;
    logic              w_we;
    logic              w_blk;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_wdata;

    state_e            r_state;
    logic              r_last_gnt;
    logic              r_owner;
    logic              r_we;
    logic              r_blk;
    logic              r_memwr;
    logic              r_err;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rsp_valid;

    rr_arb2 u_rr_arb2 (
        .i_valid    (bus.req_valid),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt)
    );

    // A non-zero grant implies its valid bit is set, so this is the handshake.
    assign w_acc   = (r_state == IDLE) && (|w_gnt);
    assign w_port  = w_gnt[1];
    assign w_we    = bus.req_we[w_port];
    assign w_adr   = w_port ? bus.req_adr[2*ADDR_W-1:ADDR_W] : bus.req_adr[ADDR_W-1:0];
    assign w_wdata = w_port ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

`ifdef MEM_WP_EN
    assign w_blk = (w_port == 1'(P_DMA)) && w_we && (w_adr < WP_LIMIT);
`else
    logic w_unused_wp;
    assign w_blk       = 1'b0;
    assign w_unused_wp = ^WP_LIMIT;
`endif

    assign bus.req_ready = (r_state == IDLE) ? w_gnt : 2'b00;
    assign bus.memwr     = r_memwr;
    assign bus.adr       = r_adr;
    assign bus.wrdata    = r_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_blk       <= 1'b0;
            r_memwr     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 4'd0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_adr      <= w_adr;
                        r_wdata    <= w_wdata;
                        r_we       <= w_we;
                        r_blk      <= w_blk;
                        r_owner    <= w_port;
                        r_last_gnt <= w_port;
                        r_memwr    <= w_we & ~w_blk;
                        r_cnt      <= 4'(WAIT_CYCLES);
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_memwr     <= 1'b0;
                        r_err       <= r_blk;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        if (!r_we) begin
                            r_rdata <= bus.memdata;
                        end
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 2'b00;
                    r_err       <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: DUT index 0 has WAIT_CYCLES=0, index 1 has WAIT_CYCLES=3.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .WP_LIMIT(8'h10)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3), .WP_LIMIT(8'h10)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    // Memory models with a preload port used only while the DUTs sit in reset.
    logic [7:0] mem0 [256];
    logic [7:0] mem3 [256];
    logic       ld_we;
    logic [7:0] ld_a;
    logic [7:0] ld_d;

    assign bus0.memdata = mem0[bus0.adr];
    assign bus3.memdata = mem3[bus3.adr];

    always @(posedge clk) begin
        if (ld_we) mem0[ld_a] <= ld_d;
        else if (bus0.memwr) mem0[bus0.adr] <= bus0.wrdata;
    end

    always @(posedge clk) begin
        if (ld_we) mem3[ld_a] <= ld_d;
        else if (bus3.memwr) mem3[bus3.adr] <= bus3.wrdata;
    end

    logic [1:0]  valid  [2];
    logic [1:0]  we_in  [2];
    logic [15:0] adr_in [2];
    logic [15:0] wd_in  [2];

    assign bus0.req_valid = valid[0];
    assign bus0.req_we    = we_in[0];
    assign bus0.req_adr   = adr_in[0];
    assign bus0.req_wdata = wd_in[0];
    assign bus3.req_valid = valid[1];
    assign bus3.req_we    = we_in[1];
    assign bus3.req_adr   = adr_in[1];
    assign bus3.req_wdata = wd_in[1];

    logic [1:0] ready_o [2];
    logic [1:0] rsp_o   [2];
    logic       memwr_o [2];
    logic [7:0] adr_o   [2];
    logic [7:0] wd_o    [2];
    logic [7:0] rd_o    [2];
    logic       err_o   [2];

    assign ready_o[0] = bus0.req_ready;
    assign rsp_o[0]   = bus0.rsp_valid;
    assign memwr_o[0] = bus0.memwr;
    assign adr_o[0]   = bus0.adr;
    assign wd_o[0]    = bus0.wrdata;
    assign rd_o[0]    = bus0.rsp_rdata;
    assign err_o[0]   = bus0.rsp_err;
    assign ready_o[1] = bus3.req_ready;
    assign rsp_o[1]   = bus3.rsp_valid;
    assign memwr_o[1] = bus3.memwr;
    assign adr_o[1]   = bus3.adr;
    assign wd_o[1]    = bus3.wrdata;
    assign rd_o[1]    = bus3.rsp_rdata;
    assign err_o[1]   = bus3.rsp_err;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on DUT d, port p. lat counts cycles from accept to rsp_valid[p];
    // wr counts memwr cycles and bad counts cycles where adr differed, both before RESP.
    task automatic txn(input int d, input int p, input logic w, input logic [7:0] a,
                       input logic [7:0] wdat, output logic [7:0] rd, output logic er,
                       output int lat, output int wr, output int bad);
        int n;
        lat = 0; wr = 0; bad = 0; rd = 8'h00; er = 1'b0; n = 0;
        @(negedge clk);
        valid[d][p] = 1'b1;
        we_in[d][p] = w;
        adr_in[d][p*8 +: 8] = a;
        wd_in[d][p*8 +: 8] = wdat;
        #1;
        while (!ready_o[d][p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_o[d][p]) begin
            check("accept_bound", 32'd0, 32'd1);
            valid[d][p] = 1'b0;
            return;
        end
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            valid[d][p] = 1'b0;
            if (rsp_o[d][p]) break;
            if (memwr_o[d]) wr++;
            if (adr_o[d] != a) bad++;
        end
        rd = rd_o[d];
        er = err_o[d];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat, wr, bad, got, cyc, prev, p;

        for (int i = 0; i < 2; i++) begin
            valid[i] = 2'b00; we_in[i] = 2'b00; adr_in[i] = 16'h0; wd_in[i] = 16'h0;
        end
        ld_we = 1'b0; ld_a = 8'h00; ld_d = 8'h00;

        // Preload while in reset.
        @(negedge clk); ld_we = 1'b1; ld_a = 8'h03; ld_d = 8'hA5;
        @(negedge clk); ld_a = 8'h05; ld_d = 8'h11;
        @(negedge clk); ld_we = 1'b0;

        check("rst_memwr",  memwr_o[0], 0);
        check("rst_adr",    adr_o[0],   0);
        check("rst_wrdata", wd_o[0],    0);
        check("rst_ready",  ready_o[0], 0);
        check("rst_rsp",    rsp_o[0],   0);
        check("rst_rdata",  rd_o[0],    0);
        check("rst_err",    err_o[0],   0);

        @(negedge clk); reset_n = 1'b1;

        // Port-0 read of the preloaded location.
        txn(0, 0, 1'b0, 8'h03, 8'h00, rd, er, lat, wr, bad);
        check("rd0_lat",   lat,      2);
        check("rd0_rsp",   rsp_o[0], 2'b01);
        check("rd0_rdata", rd,       8'hA5);
        check("rd0_memwr", wr,       0);
        check("rd0_adr",   bad,      0);

        // Port-1 write then read back.
        txn(0, 1, 1'b1, 8'h20, 8'h44, rd, er, lat, wr, bad);
        check("wr1_lat",   lat,      2);
        check("wr1_memwr", wr,       1);
        check("wr1_rsp",   rsp_o[0], 2'b10);
        check("wr1_err",   er,       0);
        txn(0, 1, 1'b0, 8'h20, 8'h00, rd, er, lat, wr, bad);
        check("rd1_rdata", rd,       8'h44);
        check("rd1_err",   er,       0);

        // Both ports held valid: alternating grants, one response every 3 cycles.
        @(negedge clk);
        valid[0] = 2'b11; we_in[0] = 2'b00; adr_in[0] = {8'h20, 8'h03};
        got = 0; cyc = 0; prev = 0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_o[0] != 2'b00) begin
                p = int'(rsp_o[0][1]);
                check("rr_onehot", $countones(rsp_o[0]), 1);
                check("rr_order",  p, got % 2);
                check("rr_rdata",  rd_o[0], (p == 1) ? 8'h44 : 8'hA5);
                if (got > 0) check("rr_spacing", cyc - prev, 3);
                prev = cyc;
                got++;
                if (got == 6) valid[0] = 2'b00;
            end
        end
        valid[0] = 2'b00;
        check("rr_count", got, 6);

        // WAIT_CYCLES=3: five-cycle latency, address stable across four ACCESS cycles.
        txn(1, 0, 1'b0, 8'h03, 8'h00, rd, er, lat, wr, bad);
        check("ws_rd_lat",   lat, 5);
        check("ws_rd_adr",   bad, 0);
        check("ws_rd_rdata", rd,  8'hA5);
        txn(1, 0, 1'b1, 8'h07, 8'h5A, rd, er, lat, wr, bad);
        check("ws_wr_lat",   lat, 5);
        check("ws_wr_memwr", wr,  4);
        txn(1, 1, 1'b0, 8'h07, 8'h00, rd, er, lat, wr, bad);
        check("ws_rb_rdata", rd,  8'h5A);
        check("ws_rb_rsp",   rsp_o[1], 2'b10);

        // Reset during the ACCESS cycle of a port-1 write.
        @(negedge clk);
        valid[0] = 2'b10; we_in[0] = 2'b10; adr_in[0] = {8'h30, 8'h00}; wd_in[0] = {8'h99, 8'h00};
        #1 check("rstm_ready", ready_o[0], 2'b10);
        @(negedge clk);
        valid[0] = 2'b00; we_in[0] = 2'b00;
        #1 check("rstm_memwr_pre", memwr_o[0], 1);
        reset_n = 1'b0;
        #1 check("rstm_memwr_drop", memwr_o[0], 0);
        check("rstm_rdata", rd_o[0], 0);
        repeat (2) begin
            @(negedge clk);
            check("rstm_no_rsp", rsp_o[0], 0);
        end
        reset_n = 1'b1;
        valid[0] = 2'b11; adr_in[0] = {8'h20, 8'h03};
        #1 check("rstm_tie_port0", ready_o[0], 2'b01);
        @(negedge clk);
        valid[0] = 2'b00;
        @(negedge clk);
        check("rstm_tie_rsp",   rsp_o[0], 2'b01);
        check("rstm_tie_rdata", rd_o[0],  8'hA5);

`ifdef MEM_WP_EN
        txn(0, 1, 1'b1, 8'h05, 8'h77, rd, er, lat, wr, bad);
        check("wp_dma_memwr", wr,  0);
        check("wp_dma_err",   er,  1);
        check("wp_dma_lat",   lat, 2);
        check("wp_dma_mem",   mem0[5], 8'h11);
        txn(0, 0, 1'b1, 8'h05, 8'h66, rd, er, lat, wr, bad);
        check("wp_cpu_memwr", wr,  1);
        check("wp_cpu_err",   er,  0);
        txn(0, 1, 1'b0, 8'h05, 8'h00, rd, er, lat, wr, bad);
        check("wp_dma_rd",     rd, 8'h66);
        check("wp_dma_rd_err", er, 0);
`else
        txn(0, 1, 1'b1, 8'h05, 8'h77, rd, er, lat, wr, bad);
        check("nowp_dma_memwr", wr, 1);
        check("nowp_dma_err",   er, 0);
        txn(0, 1, 1'b0, 8'h05, 8'h00, rd, er, lat, wr, bad);
        check("nowp_dma_rd",    rd, 8'h77);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
